// File: rtl/seg7_pkg.sv
// ============================================================================
// Module : seg7_pkg
// Desc   : Shared types and constants for the 7-segment display controller.
//          Holds the FSM state encoding, the segment patterns used for blank
//          and dash, and a power-of-ten helper for the overflow threshold.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_LATCH = 2'd3
   } state_t;

   // Active-low {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // 10^n, evaluated at elaboration time for the overflow limit.
   function automatic longint pow10(input int n);
      longint r;
      r = 1;
      for (int i = 0; i < n; i++) begin
         r = r * 10;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg7.sv
// ============================================================================
// Module : bcd_to_seg7
// Desc   : Combinational BCD nibble to active-low 7-segment pattern
//          {g,f,e,d,c,b,a}. Non-decimal nibbles (10..15) are blank.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   // Digit lookup for a common-anode display.
   always_comb begin
      seg_o = SEG_BLANK;
      unique case (nibble_i)
         4'd0:    seg_o = 7'h40;
         4'd1:    seg_o = 7'h79;
         4'd2:    seg_o = 7'h24;
         4'd3:    seg_o = 7'h30;
         4'd4:    seg_o = 7'h19;
         4'd5:    seg_o = 7'h12;
         4'd6:    seg_o = 7'h02;
         4'd7:    seg_o = 7'h78;
         4'd8:    seg_o = 7'h00;
         4'd9:    seg_o = 7'h10;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/decimal_to_bcd.sv
// ============================================================================
// Module : decimal_to_bcd
// Desc   : Iterative binary-to-BCD converter (shift-and-add-3). A start_i
//          pulse loads binary_i; INPUT_WIDTH cycles later done_o pulses for
//          one cycle and bcd_o holds the result until the next conversion.
//          Digits beyond DECIMAL_DIGITS are discarded. INPUT_WIDTH >= 2.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module decimal_to_bcd #(
   parameter int INPUT_WIDTH    = 8,
   parameter int DECIMAL_DIGITS = 3
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          start_i,
   input  logic [INPUT_WIDTH-1:0]        binary_i,
   output logic                          done_o,
   output logic [DECIMAL_DIGITS*4-1:0]   bcd_o
);

   localparam int c_BCD_W = DECIMAL_DIGITS * 4;
   localparam int c_CNT_W = $clog2(INPUT_WIDTH + 1);

   logic [INPUT_WIDTH-1:0] r_shift;
   logic [c_BCD_W-1:0]     r_work;
   logic [c_BCD_W-1:0]     w_adj;
   logic [c_BCD_W-1:0]     w_work_next;
   logic [c_BCD_W-1:0]     r_bcd;
   logic [c_CNT_W-1:0]     r_count;
   logic                   r_done;

   // Add 3 to every digit >= 5, then shift in the next binary bit.
   always_comb begin
      w_adj = r_work;
      for (int k = 0; k < DECIMAL_DIGITS; k++) begin
         if (r_work[k*4 +: 4] >= 4'd5) begin
            w_adj[k*4 +: 4] = r_work[k*4 +: 4] + 4'd3;
         end
      end
      w_work_next = {w_adj[c_BCD_W-2:0], r_shift[INPUT_WIDTH-1]};
   end

   // Shift sequencer; the result is copied out on the last shift.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_shift <= '0;
         r_work  <= '0;
         r_bcd   <= '0;
         r_count <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (start_i) begin
            r_shift <= binary_i;
            r_work  <= '0;
            r_count <= c_CNT_W'(INPUT_WIDTH);
         end else if (r_count != '0) begin
            r_shift <= r_shift << 1;
            r_work  <= w_work_next;
            r_count <= r_count - c_CNT_W'(1);
            if (r_count == c_CNT_W'(1)) begin
               r_done <= 1'b1;
               r_bcd  <= w_work_next;
            end
         end
      end
   end

   assign done_o = r_done;
   assign bcd_o  = r_bcd;

endmodule

`default_nettype wire

// File: rtl/seg7_display_ctrl.sv
// ============================================================================
// Module : seg7_display_ctrl
// Desc   : Captures a binary value on load_i, converts it with one
//          decimal_to_bcd instance, latches the BCD result and scans it onto
//          a multiplexed active-low common-anode 7-segment display.
//          Optional macro SEG7_LZ_BLANK_EN: blank leading zero digits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_display_ctrl
   import seg7_pkg::*;
#(
   parameter int INPUT_WIDTH = 8,
   parameter int DIGITS      = 3,
   parameter int SCAN_DIV    = 50000
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [INPUT_WIDTH-1:0]  value_i,
   input  logic                    load_i,
   output logic                    busy_o,
   output logic                    valid_o,
   output logic                    ovf_o,
   output logic [DIGITS*4-1:0]     bcd_o,
   output logic [DIGITS-1:0]       an_o,
   output logic [6:0]              seg_o
);

   localparam int     c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int     c_CNT_W = $clog2(SCAN_DIV);
   localparam longint c_POW   = pow10(DIGITS);
   localparam longint c_MAXW  = (longint'(1) << (INPUT_WIDTH + 1)) - 1;
   // Saturate when 10^DIGITS does not fit: no input can reach it then.
   localparam logic [INPUT_WIDTH:0] c_OVF_LIMIT =
      (c_POW > c_MAXW) ? '1 : (INPUT_WIDTH + 1)'(c_POW);

   state_t                  r_state;
   state_t                  w_state_next;
   logic                    w_conv_start;
   logic                    w_conv_done;
   logic [DIGITS*4-1:0]     w_conv_bcd;
   logic                    w_latch;
   logic [INPUT_WIDTH-1:0]  r_value;
   logic [INPUT_WIDTH-1:0]  r_conv_value;
   logic                    r_pending;
   logic [DIGITS*4-1:0]     r_bcd;
   logic                    r_valid;
   logic                    r_ovf;
   logic [c_CNT_W-1:0]      r_scan_cnt;
   logic [c_IDX_W-1:0]      r_digit_idx;
   logic [3:0]              w_nibble;
   logic [6:0]              w_dec_seg;
   logic [6:0]              w_seg_next;
   logic [DIGITS-1:0]       w_an_next;
   logic [DIGITS-1:0]       r_an;
   logic [6:0]              r_seg;
`ifdef SEG7_LZ_BLANK_EN
   logic [DIGITS-1:0]       w_lz_mask;
   logic [DIGITS-1:0]       r_lz_mask;
`endif

   decimal_to_bcd #(
      .INPUT_WIDTH    (INPUT_WIDTH),
      .DECIMAL_DIGITS (DIGITS)
   ) u_conv (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (w_conv_start),
      .binary_i (r_value),
      .done_o   (w_conv_done),
      .bcd_o    (w_conv_bcd)
   );

   // The result registers load on the edge that ends the done_o cycle.
   assign w_latch = (r_state == ST_WAIT) && w_conv_done;

   // FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state and converter start strobe.
   always_comb begin
      w_state_next = r_state;
      w_conv_start = 1'b0;
      unique case (r_state)
         ST_IDLE:  if (load_i || r_pending) w_state_next = ST_START;
         ST_START: begin
            w_conv_start = 1'b1;
            w_state_next = ST_WAIT;
         end
         ST_WAIT:  if (w_conv_done) w_state_next = ST_LATCH;
         ST_LATCH: w_state_next = r_pending ? ST_START : ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // Input capture and single-entry pending queue (last value wins).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_value      <= '0;
         r_conv_value <= '0;
         r_pending    <= 1'b0;
      end else begin
         if (load_i) r_value <= value_i;
         if (r_state == ST_START) r_conv_value <= r_value;
         unique case (r_state)
            ST_IDLE:  r_pending <= 1'b0;
            ST_START,
            ST_WAIT:  if (load_i) r_pending <= 1'b1;
            // A restart re-reads r_value, so a load here is already covered.
            ST_LATCH: r_pending <= r_pending ? 1'b0 : load_i;
            default:  r_pending <= 1'b0;
         endcase
      end
   end

`ifdef SEG7_LZ_BLANK_EN
   // Digit k > 0 blanks when it and every digit above it are zero.
   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      w_lz_mask  = '0;
      for (int k = DIGITS - 1; k > 0; k--) begin
         zero_above   = zero_above && (w_conv_bcd[k*4 +: 4] == 4'd0);
         w_lz_mask[k] = zero_above;
      end
   end
`endif

   // Display register: BCD result, valid and overflow flags.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_bcd     <= '0;
         r_valid   <= 1'b0;
         r_ovf     <= 1'b0;
`ifdef SEG7_LZ_BLANK_EN
         r_lz_mask <= '0;
`endif
      end else if (w_latch) begin
         r_bcd     <= w_conv_bcd;
         r_valid   <= 1'b1;
         r_ovf     <= ({1'b0, r_conv_value} >= c_OVF_LIMIT);
`ifdef SEG7_LZ_BLANK_EN
         r_lz_mask <= w_lz_mask;
`endif
      end
   end

   // Free-running scan divider and digit index.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_scan_cnt  <= '0;
         r_digit_idx <= '0;
      end else if (r_scan_cnt == c_CNT_W'(SCAN_DIV - 1)) begin
         r_scan_cnt  <= '0;
         r_digit_idx <= (r_digit_idx == c_IDX_W'(DIGITS - 1)) ?
                        '0 : r_digit_idx + c_IDX_W'(1);
      end else begin
         r_scan_cnt <= r_scan_cnt + c_CNT_W'(1);
      end
   end

   // Select the nibble of the digit being scanned.
   always_comb begin
      w_nibble = r_bcd[3:0];
      for (int k = 0; k < DIGITS; k++) begin
         if (r_digit_idx == c_IDX_W'(k)) w_nibble = r_bcd[k*4 +: 4];
      end
   end

   bcd_to_seg7 u_dec (
      .nibble_i (w_nibble),
      .seg_o    (w_dec_seg)
   );

   // Anode/segment selection: blank until valid, dashes on overflow.
   always_comb begin
      w_an_next  = '1;
      w_seg_next = SEG_BLANK;
      if (r_valid) begin
         w_an_next = ~(DIGITS'(1) << r_digit_idx);
         if (r_ovf) begin
            w_seg_next = SEG_DASH;
`ifdef SEG7_LZ_BLANK_EN
         end else if (r_lz_mask[r_digit_idx]) begin
            w_seg_next = SEG_BLANK;
`endif
         end else begin
            w_seg_next = w_dec_seg;
         end
      end
   end

   // Registered display pins so anodes and segments switch together.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_an  <= '1;
         r_seg <= SEG_BLANK;
      end else begin
         r_an  <= w_an_next;
         r_seg <= w_seg_next;
      end
   end

   assign busy_o  = (r_state != ST_IDLE);
   assign valid_o = r_valid;
   assign ovf_o   = r_ovf;
   assign bcd_o   = r_bcd;
   assign an_o    = r_an;
   assign seg_o   = r_seg;

endmodule

`default_nettype wire

// File: tb/tb_seg7_display_ctrl.sv
// ============================================================================
// Module : tb_seg7_display_ctrl
// Desc   : Directed self-checking bench for seg7_display_ctrl
//          (INPUT_WIDTH=10, DIGITS=3, SCAN_DIV=4). Honours SEG7_LZ_BLANK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg7_display_ctrl;

   logic        clk_i;
   logic        rst_i;
   logic [9:0]  value_i;
   logic        load_i;
   logic        busy_o;
   logic        valid_o;
   logic        ovf_o;
   logic [11:0] bcd_o;
   logic [2:0]  an_o;
   logic [6:0]  seg_o;

   int n_tests = 0;
   int n_fail  = 0;

   seg7_display_ctrl #(
      .INPUT_WIDTH (10),
      .DIGITS      (3),
      .SCAN_DIV    (4)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .value_i (value_i),
      .load_i  (load_i),
      .busy_o  (busy_o),
      .valid_o (valid_o),
      .ovf_o   (ovf_o),
      .bcd_o   (bcd_o),
      .an_o    (an_o),
      .seg_o   (seg_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pulse load_i for one cycle; busy_o must be high the cycle after.
   task automatic do_load(input logic [9:0] v);
      @(negedge clk_i);
      value_i = v;
      load_i  = 1'b1;
      @(negedge clk_i);
      load_i  = 1'b0;
      check("busy_after_load", busy_o, 1'b1);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_i);
         if (!busy_o) begin
            ok = 1'b1;
            break;
         end
      end
      check("idle_timeout", ok, 1'b1);
   endtask

   // Align to the first cycle of digit 0, then check 4 cycles per digit.
   task automatic scan_check(input string tag, input logic [6:0] e0,
                             input logic [6:0] e1, input logic [6:0] e2);
      logic [6:0] exp_seg [3];
      logic [2:0] exp_an  [3];
      bit ok;
      exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2;
      exp_an[0] = 3'b110; exp_an[1] = 3'b101; exp_an[2] = 3'b011;
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk_i);
         if (an_o == 3'b011) begin ok = 1'b1; break; end
      end
      if (ok) begin
         ok = 1'b0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (an_o == 3'b110) begin ok = 1'b1; break; end
         end
      end
      check({tag, "_align"}, ok, 1'b1);
      if (ok) begin
         for (int c = 0; c < 12; c++) begin
            check({tag, "_an"}, an_o, exp_an[c/4]);
            check({tag, "_seg"}, seg_o, exp_seg[c/4]);
            @(negedge clk_i);
         end
      end
   endtask

   initial begin
      bit ok;
      bit seen45;
      int busy_cnt;

      rst_i   = 1'b1;
      load_i  = 1'b0;
      value_i = '0;
      repeat (3) @(negedge clk_i);
      check("rst_busy",  busy_o,  1'b0);
      check("rst_valid", valid_o, 1'b0);
      check("rst_ovf",   ovf_o,   1'b0);
      check("rst_bcd",   bcd_o,   12'h000);
      check("rst_an",    an_o,    3'b111);
      check("rst_seg",   seg_o,   7'h7F);
      rst_i = 1'b0;

      // No load: display stays blank.
      repeat (20) @(negedge clk_i);
      check("noload_an",    an_o,    3'b111);
      check("noload_seg",   seg_o,   7'h7F);
      check("noload_valid", valid_o, 1'b0);
      check("noload_busy",  busy_o,  1'b0);

      // 123 with latency check around done_o.
      do_load(10'd123);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (dut.w_conv_done) begin ok = 1'b1; break; end
         @(negedge clk_i);
      end
      check("done_timeout", ok, 1'b1);
      check("pre_latch_valid", valid_o, 1'b0);
      check("pre_latch_bcd",   bcd_o,   12'h000);
      @(posedge clk_i);
      #1;
      check("lat_valid", valid_o, 1'b1);
      check("lat_bcd",   bcd_o,   12'h123);
      check("lat_ovf",   ovf_o,   1'b0);
      wait_idle();
      scan_check("d123", 7'h30, 7'h24, 7'h79);

      // 45 then 200 while busy: back-to-back conversions.
      do_load(10'd45);
      @(negedge clk_i);
      check("busy_45", busy_o, 1'b1);
      value_i = 10'd200;
      load_i  = 1'b1;
      @(negedge clk_i);
      load_i  = 1'b0;
      seen45  = 1'b0;
      ok      = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_i);
         if (bcd_o == 12'h045) seen45 = 1'b1;
         if (!busy_o) begin ok = 1'b1; break; end
      end
      check("pend_timeout", ok, 1'b1);
      check("pend_seen45", seen45, 1'b1);
      check("pend_bcd200", bcd_o, 12'h200);
      scan_check("d200", 7'h40, 7'h40, 7'h24);

      // Overflow boundary.
      do_load(10'd1000);
      wait_idle();
      check("ovf1000", ovf_o, 1'b1);
      check("valid1000", valid_o, 1'b1);
      scan_check("d1000", 7'h3F, 7'h3F, 7'h3F);
      do_load(10'd999);
      wait_idle();
      check("ovf999", ovf_o, 1'b0);
      check("bcd999", bcd_o, 12'h999);
      scan_check("d999", 7'h10, 7'h10, 7'h10);

      // Leading zeros.
      do_load(10'd7);
      wait_idle();
      check("bcd7", bcd_o, 12'h007);
`ifdef SEG7_LZ_BLANK_EN
      scan_check("d7", 7'h78, 7'h7F, 7'h7F);
`else
      scan_check("d7", 7'h78, 7'h40, 7'h40);
`endif
      do_load(10'd0);
      wait_idle();
      check("bcd0", bcd_o, 12'h000);
`ifdef SEG7_LZ_BLANK_EN
      scan_check("d0", 7'h40, 7'h7F, 7'h7F);
`else
      scan_check("d0", 7'h40, 7'h40, 7'h40);
`endif

      // Asynchronous reset during WAIT with a pending load.
      do_load(10'd123);
      @(negedge clk_i);
      value_i = 10'd45;
      load_i  = 1'b1;
      @(negedge clk_i);
      load_i  = 1'b0;
      repeat (2) @(negedge clk_i);
      check("mid_busy", busy_o, 1'b1);
      #2 rst_i = 1'b1;
      #1;
      check("arst_busy",  busy_o,  1'b0);
      check("arst_valid", valid_o, 1'b0);
      check("arst_ovf",   ovf_o,   1'b0);
      check("arst_bcd",   bcd_o,   12'h000);
      check("arst_an",    an_o,    3'b111);
      check("arst_seg",   seg_o,   7'h7F);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      busy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i);
         if (busy_o) busy_cnt++;
      end
      check("post_rst_busy_cycles", busy_cnt, 0);
      check("post_rst_valid", valid_o, 1'b0);
      check("post_rst_an",    an_o,    3'b111);
      check("post_rst_seg",   seg_o,   7'h7F);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
